// File: rtl/cma_host_seq.sv
// Host command sequencer for the CMA external bus: buffers host commands in a FIFO and
// replays them as write, read, ROM-multiplier select and run/wait bus cycles.
//
// state | meaning
// IDLE  | pop next command; SETROMUL/RUN bank register updates happen here
// WR    | one-cycle external write strobe
// RD    | one-cycle external read strobe
// RDW   | wait out the read latency, then capture read data
// RUNP  | one-cycle run pulse
// RUNW  | wait for completion or timeout
// RESP  | hold response until the host accepts it
module cma_host_seq #(
  parameter int DATA_W    = 32,
  parameter int ADR_W     = 16,
  parameter int ROMUL_W   = 2,
  parameter int CMD_DEPTH = 4,
  parameter int RD_LAT    = 1,
  parameter int TIMEOUT   = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ADR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]  cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic [1:0]         rsp_status,
  output logic               o_exwe,
  output logic               o_exre,
  output logic [DATA_W-1:0]  o_exwd,
  output logic [ADR_W-1:0]   o_exa,
  output logic [ROMUL_W-1:0] o_exromul,
  output logic               o_run,
  output logic               o_cbank,
  input  logic [DATA_W-1:0]  i_exrd,
  input  logic               i_done,
  output logic               o_busy
);

  localparam int PTR_W   = $clog2(CMD_DEPTH);
  localparam int ENT_W   = 2 + ADR_W + DATA_W;
  localparam int CNT_MAX = (TIMEOUT > RD_LAT) ? TIMEOUT : RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(CMD_DEPTH);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] OP_WRITE    = 2'b00;
  localparam logic [1:0] OP_READ     = 2'b01;
  localparam logic [1:0] OP_RUN      = 2'b10;
  localparam logic [1:0] OP_SETROMUL = 2'b11;

  localparam logic [1:0] ST_READ    = 2'b00;
  localparam logic [1:0] ST_DONE    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_RDW, S_RUNP, S_RUNW, S_RESP
  } state_t;

  state_t state, state_nx;

  logic [ENT_W-1:0]  fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              full, empty, push, pop;
  logic [ENT_W-1:0]  head;
  logic [1:0]        head_op;
  logic [ADR_W-1:0]  head_addr;
  logic [DATA_W-1:0] head_data;

  logic [ADR_W-1:0]  cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic [CNT_W-1:0]  cnt;

  assign full      = (fifo_cnt == FIFO_FULL);
  assign empty     = (fifo_cnt == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;

  assign head      = fifo_mem[rd_ptr];
  assign head_op   = head[ENT_W-1 -: 2];
  assign head_addr = head[DATA_W +: ADR_W];
  assign head_data = head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_op, cmd_addr, cmd_data};
  end

  // cmd_ready comes from the registered count, so a same-cycle pop never admits an extra push
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    o_exwe    = 1'b0;
    o_exre    = 1'b0;
    o_run     = 1'b0;
    o_exa     = '0;
    o_exwd    = '0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          case (head_op)
            OP_WRITE: state_nx = S_WR;
            OP_READ:  state_nx = S_RD;
            OP_RUN:   state_nx = S_RUNP;
            default:  state_nx = S_IDLE;
          endcase
        end
      end
      S_WR: begin
        o_exwe   = 1'b1;
        o_exa    = cur_addr;
        o_exwd   = cur_data;
        state_nx = S_IDLE;
      end
      S_RD: begin
        o_exre   = 1'b1;
        o_exa    = cur_addr;
        state_nx = S_RDW;
      end
      S_RDW: begin
        if (cnt == '0) state_nx = S_RESP;
      end
      S_RUNP: begin
        o_run    = 1'b1;
        state_nx = S_RUNW;
      end
      S_RUNW: begin
        if (i_done || cnt <= CNT_W'(1)) state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign o_busy = (state != S_IDLE) || !empty;

  // Bank is latched at pop so it is already stable during the run pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      cur_data   <= '0;
      cnt        <= '0;
      rsp_data   <= '0;
      rsp_status <= '0;
      o_exromul  <= '0;
      o_cbank    <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop) begin
        cur_addr <= head_addr;
        cur_data <= head_data;
        if (head_op == OP_SETROMUL) o_exromul <= head_data[ROMUL_W-1:0];
        if (head_op == OP_RUN)      o_cbank   <= head_data[0];
      end
      case (state)
        S_RD:   cnt <= RD_LOAD;
        S_RDW: begin
          if (cnt == '0) begin
            rsp_data   <= i_exrd;
            rsp_status <= ST_READ;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RUNP: cnt <= TO_LOAD;
        // Completion takes priority over the timeout in the final wait cycle
        S_RUNW: begin
          if (i_done) begin
            rsp_data   <= '0;
            rsp_status <= ST_DONE;
          end else if (cnt <= CNT_W'(1)) begin
            rsp_data   <= '0;
            rsp_status <= ST_TIMEOUT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cma_host_seq.sv
// Directed self-checking bench for cma_host_seq with a one-cycle-latency CMA read model.
module tb_cma_host_seq;

  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        o_exwe, o_exre, o_run, o_cbank, o_busy;
  logic [31:0] o_exwd;
  logic [15:0] o_exa;
  logic [1:0]  o_exromul;
  logic [31:0] i_exrd;
  logic        i_done;

  int checks = 0;
  int failures = 0;

  cma_host_seq #(
    .DATA_W(32), .ADR_W(16), .ROMUL_W(2), .CMD_DEPTH(4), .RD_LAT(1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .o_exwe(o_exwe), .o_exre(o_exre), .o_exwd(o_exwd), .o_exa(o_exa),
    .o_exromul(o_exromul), .o_run(o_run), .o_cbank(o_cbank),
    .i_exrd(i_exrd), .i_done(i_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // CMA read port: data is valid exactly one cycle after the read strobe, garbage otherwise
  always @(posedge clk) i_exrd <= o_exre ? (32'h0000_1214 + {16'h0, o_exa}) : 32'hBAD0_BAD0;

  // Called on a negedge; returns on the negedge right after the accepting edge
  task automatic push(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL push_accept got=cmd_ready_low exp=accepted");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b0; i_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++;
    if ({rsp_valid, o_exwe, o_exre, o_run, o_cbank, o_busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=000000", {rsp_valid, o_exwe, o_exre, o_run, o_cbank, o_busy});
    end
    checks++;
    if ({o_exa, o_exwd, o_exromul, rsp_data, rsp_status} !== '0) begin
      failures++;
      $display("FAIL reset_buses got=%h/%h/%h/%h/%h exp=0", o_exa, o_exwd, o_exromul, rsp_data, rsp_status);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write;
    int we_cnt, first_idx, bad_addr, rsp_seen;
    we_cnt = 0; first_idx = -1; bad_addr = 0; rsp_seen = 0;
    rsp_ready = 1'b1;
    push(2'b00, 16'h0010, 32'h0000_CAFE);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
      if (o_exwe) begin
        we_cnt++;
        if (first_idx < 0) first_idx = i;
        checks++;
        if (o_exa !== 16'h0010 || o_exwd !== 32'h0000_CAFE) begin
          failures++;
          $display("FAIL write_bus got=a%h d%h exp=a0010 d0000cafe", o_exa, o_exwd);
        end
      end else if (o_exa !== 16'h0 || o_exwd !== 32'h0) bad_addr++;
    end
    rsp_ready = 1'b0;
    checks++;
    if (we_cnt !== 1 || first_idx !== 0) begin
      failures++;
      $display("FAIL write_pulse got=cnt%0d idx%0d exp=cnt1 idx0", we_cnt, first_idx);
    end
    checks++;
    if (bad_addr !== 0 || rsp_seen !== 0) begin
      failures++;
      $display("FAIL write_idle_bus got=bad%0d rsp%0d exp=0 0", bad_addr, rsp_seen);
    end
  endtask

  task automatic test_read;
    push(2'b01, 16'h0020, 32'h0);
    @(negedge clk);
    checks++;
    if (o_exre !== 1'b1 || o_exa !== 16'h0020 || o_exwe !== 1'b0) begin
      failures++;
      $display("FAIL read_strobe got=re%b a%h we%b exp=re1 a0020 we0", o_exre, o_exa, o_exwe);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || o_exre !== 1'b0 || o_exa !== 16'h0) begin
      failures++;
      $display("FAIL read_wait got=v%b re%b a%h exp=v0 re0 a0000", rsp_valid, o_exre, o_exa);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_1234 || rsp_status !== 2'b00 || o_busy !== 1'b1) begin
        failures++;
        $display("FAIL read_rsp_hold%0d got=v%b d%h s%b b%b exp=v1 d00001234 s00 b1",
                 i, rsp_valid, rsp_data, rsp_status, o_busy);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL read_handshake got=v%b b%b exp=v0 b0", rsp_valid, o_busy);
    end
  endtask

  task automatic test_setromul;
    push(2'b11, 16'h0, 32'hFFFF_FFF3);
    @(negedge clk);
    checks++;
    if (o_exromul !== 2'd3 || rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL setromul got=m%0d v%b b%b exp=m3 v0 b0", o_exromul, rsp_valid, o_busy);
    end
  endtask

  task automatic test_run_done;
    int stray;
    stray = 0;
    push(2'b10, 16'h0, 32'h0000_0001);
    @(negedge clk);
    checks++;
    if (o_run !== 1'b1 || o_cbank !== 1'b1) begin
      failures++;
      $display("FAIL run_pulse got=run%b bank%b exp=run1 bank1", o_run, o_cbank);
    end
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (o_run || rsp_valid || !o_cbank) stray++;
      if (k == 50) i_done = 1'b1;
    end
    @(negedge clk);
    i_done = 1'b0;
    checks++;
    if (stray !== 0) begin failures++; $display("FAIL run_wait_quiet got=%0d exp=0", stray); end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || rsp_data !== 32'h0) begin
      failures++;
      $display("FAIL run_done_rsp got=v%b s%b d%h exp=v1 s01 d0", rsp_valid, rsp_status, rsp_data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || o_cbank !== 1'b1) begin
      failures++;
      $display("FAIL run_done_after got=v%b bank%b exp=v0 bank1", rsp_valid, o_cbank);
    end
  endtask

  task automatic test_run_timeout;
    int k;
    push(2'b10, 16'h0, 32'h0000_0000);
    @(negedge clk);
    checks++;
    if (o_run !== 1'b1 || o_cbank !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse got=run%b bank%b exp=run1 bank0", o_run, o_cbank);
    end
    k = 0;
    while (!rsp_valid && k < TIMEOUT + 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== TIMEOUT || rsp_status !== 2'b10 || rsp_data !== 32'h0) begin
      failures++;
      $display("FAIL run_timeout got=k%0d s%b d%h exp=k%0d s10 d0", k, rsp_status, rsp_data, TIMEOUT);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_done_at_timeout;
    push(2'b10, 16'h0, 32'h0000_0001);
    @(negedge clk);
    for (int k = 1; k <= TIMEOUT - 1; k++) begin
      @(negedge clk);
      if (k == TIMEOUT - 1) i_done = 1'b1;
    end
    @(negedge clk);
    i_done = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b01) begin
      failures++;
      $display("FAIL done_wins got=v%b s%b exp=v1 s01", rsp_valid, rsp_status);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [1:0]  ev_kind [$];
    logic [15:0] ev_addr [$];
    logic [31:0] ev_data [$];
    logic [1:0]  exp_kind [5] = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [15:0] exp_addr [5] = '{16'h0, 16'h0040, 16'h0, 16'h0, 16'h0060};
    logic [31:0] exp_data [5] = '{32'h1244, 32'h11, 32'h1264, 32'h2, 32'h22};
    logic [1:0]  prev_romul;
    rsp_ready = 1'b0;
    push(2'b01, 16'h0030, 32'h0);
    push(2'b00, 16'h0040, 32'h0000_0011);
    push(2'b01, 16'h0050, 32'h0);
    push(2'b11, 16'h0, 32'h0000_0002);
    push(2'b00, 16'h0060, 32'h0000_0022);
    checks++;
    if (cmd_ready !== 1'b0 || o_busy !== 1'b1 || rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL fifo_full got=rdy%b b%b v%b exp=rdy0 b1 v1", cmd_ready, o_busy, rsp_valid);
    end
    prev_romul = o_exromul;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (o_exwe) begin ev_kind.push_back(2'd1); ev_addr.push_back(o_exa); ev_data.push_back(o_exwd); end
      if (rsp_valid) begin ev_kind.push_back(2'd2); ev_addr.push_back(16'h0); ev_data.push_back(rsp_data); end
      if (o_exromul !== prev_romul) begin
        ev_kind.push_back(2'd3); ev_addr.push_back(16'h0); ev_data.push_back({30'h0, o_exromul});
        prev_romul = o_exromul;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    checks++;
    if (ev_kind.size() !== 5) begin
      failures++;
      $display("FAIL b2b_event_count got=%0d exp=5", ev_kind.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (ev_kind[i] !== exp_kind[i] || ev_addr[i] !== exp_addr[i] || ev_data[i] !== exp_data[i]) begin
          failures++;
          $display("FAIL b2b_event%0d got=k%0d a%h d%h exp=k%0d a%h d%h", i,
                   ev_kind[i], ev_addr[i], ev_data[i], exp_kind[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    checks++;
    if (o_busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_drained got=b%b rdy%b exp=b0 rdy1", o_busy, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    int stray;
    stray = 0;
    push(2'b10, 16'h0, 32'h0000_0001);
    push(2'b00, 16'h0070, 32'h0000_0077);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({rsp_valid, o_exwe, o_exre, o_run, o_cbank, o_busy} !== 6'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_strobes got=%b rdy%b exp=000000 rdy1",
               {rsp_valid, o_exwe, o_exre, o_run, o_cbank, o_busy}, cmd_ready);
    end
    checks++;
    if ({o_exa, o_exwd, o_exromul, rsp_data, rsp_status} !== '0) begin
      failures++;
      $display("FAIL mid_reset_buses got=%h/%h/%h/%h/%h exp=0", o_exa, o_exwd, o_exromul, rsp_data, rsp_status);
    end
    rsp_ready = 1'b1;
    i_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid || o_exwe || o_run || o_busy) stray++;
    end
    i_done = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (stray !== 0) begin failures++; $display("FAIL mid_reset_stale got=%0d exp=0", stray); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_setromul();
    test_run_done();
    test_run_timeout();
    test_done_at_timeout();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
